unit_result_fifo: RTL and testbench
===================================

# unit_result_fifo

Result buffer placed directly downstream of the `unit` expression stage. It captures every `valid_out`/`Q` result pair, including back-to-back results, into a small circular FIFO. It re-presents the results to the consumer over a ready/valid handshake. The upstream stage has no backpressure, so results arriving while the FIFO is full are dropped and flagged.

## Interface
- `WIDTH`, 16: operand width of the upstream stage. Data width is 2*WIDTH.
- `DEPTH`, 4: number of FIFO entries. Must be a power of two, ≥ 2.
- `CNT_WIDTH`, 8: width of the drop counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `valid_in`  in  1  result strobe from the upstream `valid_out`.
- `q_in`  in  2*WIDTH  signed result from the upstream `Q`.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  2*WIDTH  signed head entry.
- `level`  out  $clog2(DEPTH+1)  number of occupied entries.
- `overflow`  out  1  sticky flag: at least one result was dropped.
- `clr_ovf`  in  1  clears `overflow` (and `drop_cnt` when compiled in).
- `drop_cnt`  out  CNT_WIDTH  count of dropped results. Present only with `UNIT_FIFO_DROP_CNT_EN`.

## Operation
**Reset** (`rst`=0 at a rising edge):
- Read pointer, write pointer, `level`, `overflow` and `drop_cnt` go to 0.
- All memory entries go to 0.
- Outputs therefore read `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0.
- Reset overrides every other input in that cycle, including mid-transfer. Any buffered results are discarded.

**Push:**
- Occurs when `valid_in`=1 and the FIFO is not full after accounting for a same-cycle pop.
- `q_in` is written at the write pointer, and the write pointer increments modulo DEPTH.

**Pop:**
- Occurs when `out_valid`=1 and `out_ready`=1.
- The read pointer increments modulo DEPTH.

**Level:**
- `level` increases by 1 on push only.
- `level` decreases by 1 on pop only.
- `level` is unchanged on push and pop together, or on neither.

**Outputs:**
- `out_valid` = (`level` != 0).
- `out_data` = mem[read pointer]. Both are driven from registered state.
- `out_data` must hold stable while `out_valid`=1 and `out_ready`=0.

**Full:**
- If `valid_in`=1, `level`=DEPTH and no pop occurs, the result is dropped. Memory and pointers are untouched.
- In that case `overflow` is set.
- If `valid_in`=1, `level`=DEPTH and a pop occurs in the same cycle, the push is accepted and `level` stays at DEPTH.

**Empty:**
- `out_ready` is ignored when `level`=0.
- A push into an empty FIFO is visible at the output on the next cycle.
- There is no combinational bypass.

**Overflow clear:**
- `clr_ovf`=1 clears `overflow` on the next edge.
- If a drop occurs in the same cycle as `clr_ovf`, the set wins: `overflow`=1 afterwards. With the counter compiled in, `drop_cnt`=1 afterwards.

**Pointer wrap-around:**
- Pointers wrap from DEPTH-1 to 0 with no gap or duplicate.
- Full and empty are distinguished by `level`, not by pointer equality.

## Timing
- Push latency: `valid_in` sampled at edge N, then `out_valid`=1 and `out_data`=`q_in` from edge N onward (visible in cycle N+1).
- Pop: the handshake at edge N presents the next entry (or `out_valid`=0) after edge N.
- Throughput: one push and one pop per cycle, sustained indefinitely at any level.
- `level`, `overflow` and `drop_cnt` update on the same edge as the event that causes them.
- Single-cycle `valid_in` pulses and continuous `valid_in` are both accepted.

## Configuration
**`UNIT_FIFO_DROP_CNT_EN` defined:**
- The `drop_cnt` port and its register exist.
- The register increments by 1 per dropped result.
- It saturates at 2^CNT_WIDTH-1 and does not wrap.
- It is cleared by reset or `clr_ovf`.

**Not defined:**
- The `drop_cnt` port and its register are absent.
- All other behaviour is identical.

## Test plan
- **Reset check.** Reset for 2 cycles, then release → `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0. Apply `out_ready`=1 with no pushes → nothing changes.
- **In-order delivery.** `out_ready`=0. Push 31, -22 and 32767×32767 on consecutive cycles → `level`=3. Set `out_ready`=1 → outputs 31, -22, 1073676289 on three consecutive cycles, then `out_valid`=0.
- **Overflow.** DEPTH=4, `out_ready`=0. Push 1, 2, 3, 4, 5, 6 → `level`=4 and `overflow`=1, `drop_cnt`=2 (macro on). Drain → 1, 2, 3, 4 only. Pulse `clr_ovf` → `overflow`=0, `drop_cnt`=0.
- **Full with simultaneous push and pop.** Fill with 10..13. Then `out_ready`=1 with a push of 14 → 10 pops, `level` stays 4, and the later drain order is 11, 12, 13, 14. `overflow` stays 0.
- **Wrap-around and random stress.** Run 200 cycles of random `valid_in`, `out_ready` and signed `q_in`, checked against a queue model → every accepted value is matched in order, and `level` matches the model every cycle.
- **Mid-operation reset.** With `level`=3, assert `rst`=0 for 1 cycle while `valid_in`=1 with `q_in`=-7 → after the edge `level`=0 and `out_valid`=0, and -7 is not stored.

Source files
------------

// File: rtl/unit_result_fifo.sv
// unit_result_fifo: circular result buffer behind the `unit` expression stage.
// Captures every valid_in/q_in pair and re-presents it over ready/valid.
// The upstream stage cannot be stalled, so a result that arrives while the
// buffer is full (and nothing leaves that cycle) is dropped and flagged.
// Optional feature: define UNIT_FIFO_DROP_CNT_EN to add the saturating
// drop_cnt port and register.
module unit_result_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [2*WIDTH-1:0]    q_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [2*WIDTH-1:0]    out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic                         clr_ovf,
`ifdef UNIT_FIFO_DROP_CNT_EN
  output logic [CNT_WIDTH-1:0]         drop_cnt,
`endif
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int DW = 2*WIDTH;

  logic [DW-1:0] mem_reg [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          overflow_reg;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // Handshake decode; full/empty come from the occupancy count, never from
  // pointer equality, so the pointers can wrap freely.
  always_comb begin
    full = (level_reg == LW'(DEPTH));
    pop  = (level_reg != '0) && out_ready;
    push = valid_in && (!full || pop);
    drop = valid_in && full && !pop;
  end

  // Occupancy: +1 on push alone, -1 on pop alone, unchanged otherwise.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage: cleared on reset so an empty buffer always presents zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      mem_reg[wr_ptr_reg] <= q_in;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

`ifdef UNIT_FIFO_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_reg;

  // Saturating drop counter; a drop coinciding with a clear restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_reg <= '0;
    end else if (drop) begin
      if (clr_ovf)
        drop_cnt_reg <= CNT_WIDTH'(1);
      else if (drop_cnt_reg != '1)
        drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
    end else if (clr_ovf) begin
      drop_cnt_reg <= '0;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

  assign out_valid = (level_reg != '0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_unit_result_fifo.sv
// Directed and random checks for unit_result_fifo (DEPTH=4, WIDTH=16).
// Drop-counter checks are compiled only with UNIT_FIFO_DROP_CNT_EN.
module tb_unit_result_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_WIDTH = 8;
  localparam int DW = 2*WIDTH;

  logic                 clk;
  logic                 rst;
  logic                 valid_in;
  logic signed [DW-1:0] q_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [2:0]           level;
  logic                 clr_ovf;
  logic                 overflow;
`ifdef UNIT_FIFO_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt;
`endif

  int tests;
  int fails;
  int cyc;

  unit_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .q_in(q_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level),
    .clr_ovf(clr_ovf),
`ifdef UNIT_FIFO_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, settle, and log the transaction.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc %0d rst=%0b vin=%0b q=%0h rdy=%0b -> valid=%0b data=%0h level=%0d ovf=%0b",
             cyc, rst, valid_in, q_in, out_ready, out_valid, out_data, level, overflow);
  endtask

  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_v;
  logic          r_vin;
  logic          r_rdy;
  logic          m_pop;
  logic          m_push;

  initial begin
    tests = 0; fails = 0; cyc = 0;
    rst = 1'b0; valid_in = 1'b0; q_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;

    // Reset check
    tick(); tick();
    rst = 1'b1;
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_data", out_data, '0);
    chk("rst_level", DW'(level), DW'(0));
    chk("rst_ovf", DW'(overflow), DW'(0));
`ifdef UNIT_FIFO_DROP_CNT_EN
    chk("rst_drop", DW'(drop_cnt), DW'(0));
`endif
    out_ready = 1'b1;
    tick(); tick();
    chk("idle_ready_valid", DW'(out_valid), DW'(0));
    chk("idle_ready_level", DW'(level), DW'(0));
    chk("idle_ready_data", out_data, '0);

    // In-order delivery with back-to-back pushes
    out_ready = 1'b0;
    valid_in = 1'b1; q_in = 31;
    tick();
    chk("lat_valid", DW'(out_valid), DW'(1));
    chk("lat_data", out_data, DW'(31));
    q_in = -22;              tick();
    q_in = 32767 * 32767;    tick();
    valid_in = 1'b0;
    chk("ord_level3", DW'(level), DW'(3));
    chk("ord_hold", out_data, DW'(31));
    tick();
    chk("ord_hold2", out_data, DW'(31));
    out_ready = 1'b1;
    tick();
    chk("ord_d1", out_data, DW'(-22));
    chk("ord_l2", DW'(level), DW'(2));
    tick();
    chk("ord_d2", out_data, DW'(1073676289));
    chk("ord_l1", DW'(level), DW'(1));
    tick();
    chk("ord_empty", DW'(out_valid), DW'(0));
    chk("ord_l0", DW'(level), DW'(0));
    out_ready = 1'b0;

    // Overflow: push six into a four-entry buffer
    for (int v = 1; v <= 6; v++) begin
      valid_in = 1'b1; q_in = v;
      tick();
    end
    valid_in = 1'b0;
    chk("ovf_level", DW'(level), DW'(4));
    chk("ovf_flag", DW'(overflow), DW'(1));
`ifdef UNIT_FIFO_DROP_CNT_EN
    chk("ovf_drop", DW'(drop_cnt), DW'(2));
`endif
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain_v", DW'(out_valid), DW'(1));
      chk("ovf_drain_d", out_data, DW'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_drained", DW'(out_valid), DW'(0));
    chk("ovf_sticky", DW'(overflow), DW'(1));
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_clr", DW'(overflow), DW'(0));
`ifdef UNIT_FIFO_DROP_CNT_EN
    chk("ovf_clr_drop", DW'(drop_cnt), DW'(0));
`endif

    // Full with simultaneous push and pop
    for (int v = 10; v <= 13; v++) begin
      valid_in = 1'b1; q_in = v;
      tick();
    end
    chk("fp_full", DW'(level), DW'(4));
    out_ready = 1'b1; valid_in = 1'b1; q_in = 14;
    chk("fp_head", out_data, DW'(10));
    tick();
    out_ready = 1'b0; valid_in = 1'b0;
    chk("fp_level", DW'(level), DW'(4));
    chk("fp_ovf", DW'(overflow), DW'(0));
    chk("fp_next", out_data, DW'(11));

    // Drop and clear in the same cycle: the set wins
    valid_in = 1'b1; q_in = 99; clr_ovf = 1'b1;
    tick();
    valid_in = 1'b0; clr_ovf = 1'b0;
    chk("dc_ovf", DW'(overflow), DW'(1));
    chk("dc_level", DW'(level), DW'(4));
`ifdef UNIT_FIFO_DROP_CNT_EN
    chk("dc_drop", DW'(drop_cnt), DW'(1));
`endif
    out_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      chk("fp_drain", out_data, DW'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("fp_empty", DW'(out_valid), DW'(0));
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("fp_clr", DW'(overflow), DW'(0));

    // Random stress against a queue model (covers pointer wrap)
    for (int n = 0; n < 200; n++) begin
      r_vin = 1'($urandom_range(0, 1));
      r_rdy = 1'($urandom_range(0, 1));
      valid_in = r_vin; out_ready = r_rdy; q_in = $urandom;
      m_pop  = (model.size() != 0) && r_rdy;
      m_push = r_vin && ((model.size() < DEPTH) || m_pop);
      if (model.size() != 0) begin
        chk("rnd_data", out_data, model[0]);
      end
      if (m_pop) exp_v = model.pop_front();
      if (m_push) model.push_back(q_in);
      tick();
      chk("rnd_level", DW'(level), DW'(model.size()));
      chk("rnd_valid", DW'(out_valid), DW'(model.size() != 0));
    end
    valid_in = 1'b0; out_ready = 1'b0;

    // Mid-operation reset with a push in the same cycle
    rst = 1'b0; tick(); rst = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      valid_in = 1'b1; q_in = 100 + v;
      tick();
    end
    chk("mr_level3", DW'(level), DW'(3));
    rst = 1'b0; valid_in = 1'b1; q_in = -7; out_ready = 1'b1;
    tick();
    rst = 1'b1; valid_in = 1'b0;
    chk("mr_level", DW'(level), DW'(0));
    chk("mr_valid", DW'(out_valid), DW'(0));
    chk("mr_data", out_data, '0);
    chk("mr_ovf", DW'(overflow), DW'(0));
    tick();
    chk("mr_after_level", DW'(level), DW'(0));
    chk("mr_after_valid", DW'(out_valid), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
